// File: rtl/ext_interrupt_controller_if.sv
// Register bus between the data-memory side and ext_interrupt_controller.
// The master drives strobes, address and write data; the slave returns registered read data.
interface ext_interrupt_controller_if;
    logic        I_wen;
    logic        I_ren;
    logic [3:0]  I_addr;
    logic [31:0] I_wdata;
    logic [31:0] O_rdata;

    modport master (output I_wen, I_ren, I_addr, I_wdata, input O_rdata);
    modport slave  (input I_wen, I_ren, I_addr, I_wdata, output O_rdata);
endinterface

// File: rtl/ext_interrupt_controller.sv
// External interrupt controller: edge-latched pending, enable mask, claim/complete, one in service.
// Define EXT_INTC_SYNC_EN to insert a 2-flop synchronizer on every I_irq line.
module ext_interrupt_controller #(
    parameter int unsigned NUM_SOURCES = 8
) (
    input  logic                   I_clk,
    input  logic                   I_rst_n,
    input  logic [NUM_SOURCES-1:0] I_irq,
    ext_interrupt_controller_if.slave bus,
    output logic                   O_extinterrupt
);

    logic [NUM_SOURCES-1:0] w_s;
    logic [NUM_SOURCES-1:0] r_s_prev;
    logic [NUM_SOURCES-1:0] w_rise;
    logic [NUM_SOURCES-1:0] r_pending;
    logic [NUM_SOURCES-1:0] w_pending_nxt;
    logic [NUM_SOURCES-1:0] r_enable;
    logic [NUM_SOURCES-1:0] w_active;
    logic [NUM_SOURCES-1:0] w_win_mask;
    logic [4:0]             w_winner;
    logic [4:0]             r_in_service;
    logic [4:0]             w_in_service_cmpl;
    logic                   w_cmpl_hit;
    logic                   w_claim_ok;
    logic [31:0]            w_rdata_nxt;
    logic [31:0]            r_rdata;
    logic                   r_ext;
    logic                   w_unused;

`ifdef EXT_INTC_SYNC_EN
    logic [NUM_SOURCES-1:0] r_sync1;
    logic [NUM_SOURCES-1:0] r_sync2;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= I_irq;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2;
`else
    assign w_s = I_irq;
`endif

    assign w_rise   = w_s & ~r_s_prev;
    assign w_active = r_pending & r_enable;

    always_comb begin
        w_winner   = '0;
        w_win_mask = '0;
        for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
            if (w_active[i] && (w_winner == '0)) begin
                w_winner      = 5'(i + 1);
                w_win_mask[i] = 1'b1;
            end
        end
    end

    // Complete is resolved before claim so a same-cycle claim can take the freed slot.
    assign w_cmpl_hit = bus.I_wen && (bus.I_addr[3:2] == 2'd3)
                        && (bus.I_wdata[4:0] == r_in_service) && (r_in_service != '0);
    assign w_in_service_cmpl = w_cmpl_hit ? '0 : r_in_service;
    assign w_claim_ok = bus.I_ren && (bus.I_addr[3:2] == 2'd2)
                        && (w_in_service_cmpl == '0) && (w_winner != '0);

    // A rise in the claim cycle re-sets the bit the claim clears.
    assign w_pending_nxt = (r_pending & ~(w_claim_ok ? w_win_mask : '0)) | w_rise;

    always_comb begin
        w_rdata_nxt = '0;
        case (bus.I_addr[3:2])
            2'd0: w_rdata_nxt = 32'(r_pending);
            2'd1: w_rdata_nxt = 32'(r_enable);
            2'd2: w_rdata_nxt = w_claim_ok ? 32'(w_winner) : '0;
            2'd3: w_rdata_nxt = 32'(r_in_service);
            default: w_rdata_nxt = '0;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_s_prev     <= '0;
            r_pending    <= '0;
            r_enable     <= '0;
            r_in_service <= '0;
            r_rdata      <= '0;
            r_ext        <= 1'b0;
        end else begin
            r_s_prev     <= w_s;
            r_pending    <= w_pending_nxt;
            if (bus.I_wen && (bus.I_addr[3:2] == 2'd1))
                r_enable <= bus.I_wdata[NUM_SOURCES-1:0];
            r_in_service <= w_claim_ok ? w_winner : w_in_service_cmpl;
            if (bus.I_ren)
                r_rdata  <= w_rdata_nxt;
            r_ext        <= (|w_active) && (r_in_service == '0);
        end
    end

    assign bus.O_rdata    = r_rdata;
    assign O_extinterrupt = r_ext;

    assign w_unused = ^{bus.I_addr[1:0], bus.I_wdata};

endmodule

// File: tb/tb_ext_interrupt_controller.sv
// Directed-vector bench for ext_interrupt_controller; latencies stretch by 2 with EXT_INTC_SYNC_EN.
module tb_ext_interrupt_controller;

`ifdef EXT_INTC_SYNC_EN
    localparam int unsigned SL = 2;
`else
    localparam int unsigned SL = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] irq;
    logic       ext;
    logic [31:0] rd;
    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    ext_interrupt_controller_if bus ();

    ext_interrupt_controller #(.NUM_SOURCES(8)) dut (
        .I_clk          (clk),
        .I_rst_n        (rst_n),
        .I_irq          (irq),
        .bus            (bus),
        .O_extinterrupt (ext)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus.I_wen = 1'b1; bus.I_addr = a; bus.I_wdata = d;
        tick();
        bus.I_wen = 1'b0;
    endtask

    task automatic rdreg(input logic [3:0] a, output logic [31:0] d);
        bus.I_ren = 1'b1; bus.I_addr = a;
        tick();
        bus.I_ren = 1'b0;
        d = bus.O_rdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; irq = '0;
        bus.I_wen = 1'b0; bus.I_ren = 1'b0; bus.I_addr = '0; bus.I_wdata = '0;
        tick(); tick();
        chk("reset_ext", {31'b0, ext}, 32'h0);
        chk("reset_rdata", bus.O_rdata, 32'h0);
        rst_n = 1'b1;
        tick();
        rdreg(4'h0, rd); chk("reset_pending", rd, 32'h0);
        rdreg(4'h4, rd); chk("reset_enable", rd, 32'h0);
        rdreg(4'h8, rd); chk("reset_claim", rd, 32'h0);

        // 1: single enabled source, latency
        wr(4'h4, 32'h04);
        irq[2] = 1'b1; tick(); irq[2] = 1'b0;
        repeat (SL) tick();
        chk("t1_ext_early", {31'b0, ext}, 32'h0);
        tick();
        chk("t1_ext_on", {31'b0, ext}, 32'h1);
        rdreg(4'h0, rd); chk("t1_pending", rd, 32'h04);
        rdreg(4'h8, rd); chk("t1_claim", rd, 32'h3);
        wr(4'hC, 32'h3);

        // 2: priority, double claim, complete, next claim
        wr(4'h4, 32'hFF);
        irq = 8'h14; tick(); irq = '0;
        repeat (SL + 1) tick();
        rdreg(4'h0, rd); chk("t2_pending", rd, 32'h14);
        chk("t2_ext_before", {31'b0, ext}, 32'h1);
        rdreg(4'h8, rd); chk("t2_claim3", rd, 32'h3);
        rdreg(4'h0, rd); chk("t2_pending_after", rd, 32'h10);
        chk("t2_ext_dropped", {31'b0, ext}, 32'h0);
        rdreg(4'h8, rd); chk("t2_claim_busy", rd, 32'h0);
        wr(4'hC, 32'h3);
        tick();
        chk("t2_ext_back", {31'b0, ext}, 32'h1);
        rdreg(4'h8, rd); chk("t2_claim5", rd, 32'h5);
        wr(4'hC, 32'h5);

        // 3: pending while disabled, then enable
        wr(4'h4, 32'h0);
        irq[0] = 1'b1; tick(); irq[0] = 1'b0;
        repeat (SL + 2) tick();
        chk("t3_ext_masked", {31'b0, ext}, 32'h0);
        rdreg(4'h0, rd); chk("t3_pending", rd, 32'h01);
        wr(4'h4, 32'h01);
        chk("t3_ext_same", {31'b0, ext}, 32'h0);
        tick();
        chk("t3_ext_enabled", {31'b0, ext}, 32'h1);
        rdreg(4'h8, rd); chk("t3_claim1", rd, 32'h1);
        wr(4'hC, 32'h1);

        // 4: wrong complete ignored
        wr(4'h4, 32'hFF);
        irq[1] = 1'b1; tick(); irq[1] = 1'b0;
        repeat (SL + 1) tick();
        rdreg(4'h8, rd); chk("t4_claim2", rd, 32'h2);
        wr(4'hC, 32'h7);
        rdreg(4'hC, rd); chk("t4_insvc_kept", rd, 32'h2);
        chk("t4_ext_low", {31'b0, ext}, 32'h0);
        wr(4'hC, 32'h2);
        rdreg(4'hC, rd); chk("t4_insvc_clear", rd, 32'h0);

        // 5: rise on the source being claimed keeps it pending
        irq[1] = 1'b1; tick(); irq[1] = 1'b0;
        repeat (SL + 1) tick();
        irq[1] = 1'b1;
        repeat (SL) tick();
        rdreg(4'h8, rd); chk("t5_claim2", rd, 32'h2);
        rdreg(4'h0, rd); chk("t5_pending_kept", rd, 32'h02);
        irq[1] = 1'b0;

        // 6: reset mid-service with a line held high
        irq[3] = 1'b1;
        #2 rst_n = 1'b0;
        #2;
        chk("t6_rst_rdata", bus.O_rdata, 32'h0);
        chk("t6_rst_ext", {31'b0, ext}, 32'h0);
        tick();
        rst_n = 1'b1;
        repeat (SL) tick();
        rdreg(4'h4, rd); chk("t6_enable", rd, 32'h0);
        rdreg(4'h0, rd); chk("t6_pending", rd, 32'h08);
        rdreg(4'hC, rd); chk("t6_insvc", rd, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
